fls_datapath: RTL and testbench
===============================

Name: fls_datapath

Overview:
- Downstream consumer of the lab1 FLS control FSM. It holds the two operand registers and produces the sequence value f(n) = f(n-1) + f(n-2) on the display output.
- The FSM's 2-bit control selects the action: load first operand, load second operand, or step the sequence.
- The block samples the same synchronised `en` button level as the FSM and acts once per rising edge.

Parameters:
- WIDTH, 16, data width of operands and result.
- CNT_W, 8, width of the step counter (counter saturates at all-ones).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  synchronised button level, shared with the FSM.
- control  input  2  FSM state: 0 = load a, 1 = load b, 2 = step, 3 = reserved.
- d  input  WIDTH  operand from switches.
- f  output  WIDTH  current sequence value.
- valid  output  1  one-cycle pulse, asserted the cycle after an accepted update.
- ovf  output  1  sticky overflow flag.
- count  output  CNT_W  number of sequence terms produced.

Behaviour:
- Reset: clk and rst as named above; rst is asynchronous and active-high. While rst is high, en_q, a, b, f, count, ovf and valid are all 0 immediately, independent of clk.
- Edge detect: en_q <= en every cycle; rise = en & ~en_q.
  - This matches the FSM's last_en, so the block acts in the same cycle the FSM advances.
  - control is sampled in that cycle, i.e. the FSM's pre-transition state.
- Holding en high gives exactly one action. No action occurs while en is low or held high.
- On rise, by control value:
  - control=0: a <= d, f <= d, b <= 0, count <= 1, ovf <= 0 (clears the sticky flag; starts a new sequence).
  - control=1: b <= d, f <= d, count <= 2.
  - control=2:
    - sum = {1'b0,a} + {1'b0,b} (WIDTH+1 bits).
    - a <= b, b <= sum[WIDTH-1:0], f <= sum[WIDTH-1:0].
    - count <= count+1, saturating at 2^CNT_W-1.
    - If sum[WIDTH] = 1, then ovf <= 1 (sticky until the next control=0 load or reset).
  - control=3: no register change, valid stays 0.
- valid: registered. It is 1 for exactly the one cycle after a rise with control in {0,1,2}, otherwise 0.
- Latency: f, count and ovf are updated at the clock edge ending the rise cycle. valid is high during the following cycle, aligned with the new f.
- Back-to-back: en must return low for at least 1 cycle between presses. A rise every 2 cycles is fully supported.
- Reset mid-operation: all state is cleared and the next rise with control=0 starts fresh. The FSM resets with the same rst.
- Arithmetic is unsigned. `d` is not registered except when loaded.

Optional Feature:
- Macro: FLS_SATURATE_EN.
- Defined: on a control=2 step with carry, b <= all-ones, f <= all-ones, a <= b (old b), ovf <= 1. Later steps stay at all-ones.
- Not defined: the result wraps modulo 2^WIDTH, with ovf set as above.

Test Plan:
- rst pulse asynchronously mid-cycle -> f=0, count=0, ovf=0, valid=0 immediately, before the next clk edge.
- Press sequence d=1 (ctl 0), d=1 (ctl 1), then 4 presses with ctl 2 -> f = 1,1,2,3,5,8; count=6; one valid pulse per press; ovf=0.
- en held high for 20 cycles with ctl=2, a=2, b=3 -> single update: f=5, count increments by 1, valid high for exactly 1 cycle.
- WIDTH=16, load a=0x8000, b=0x8000, step -> f=0x0000, ovf=1. With FLS_SATURATE_EN -> f=0xFFFF, ovf=1. Then a control=0 load -> ovf=0.
- control=3 with a rise -> f, a, b and count unchanged; valid stays 0.
- After 2 loads plus 3 steps, assert rst, release, load d=7 with ctl 0 -> f=7, count=1, ovf=0, old operands gone.

Source files
------------

// File: rtl/fls_datapath.sv
// Datapath for the FLS sequence: operand registers, step adder, sticky overflow and term counter.
// Optional macro FLS_SATURATE_EN: a step that carries clamps the result to all-ones.
module fls_datapath #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] f,
    output logic             valid,
    output logic             ovf,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        CtlLoadA = 2'd0,
        CtlLoadB = 2'd1,
        CtlStep  = 2'd2,
        CtlRsvd  = 2'd3
    } ctl_e;

    logic             en_q;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic             rise;
    logic [WIDTH:0]   sum;
    logic             carry;
    logic [CNT_W-1:0] count_inc;
    ctl_e             ctl;

    // Same edge detector as the FSM's last_en, so both act in the same cycle.
    assign rise  = en & ~en_q;
    assign ctl   = ctl_e'(control);
    assign sum   = {1'b0, a_q} + {1'b0, b_q};
    assign carry = sum[WIDTH];

    always_comb begin
        count_inc = count_q;
        if (count_q != {CNT_W{1'b1}}) begin
            count_inc = count_q + CNT_W'(1);
        end
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;

        if (rise) begin
            unique case (ctl)
                CtlLoadA: begin
                    a_d     = d;
                    b_d     = '0;
                    f_d     = d;
                    count_d = CNT_W'(1);
                    ovf_d   = 1'b0;
                    valid_d = 1'b1;
                end
                CtlLoadB: begin
                    b_d     = d;
                    f_d     = d;
                    count_d = CNT_W'(2);
                    valid_d = 1'b1;
                end
                CtlStep: begin
                    a_d     = b_q;
                    count_d = count_inc;
                    valid_d = 1'b1;
                    if (carry) begin
                        ovf_d = 1'b1;
                    end
`ifdef FLS_SATURATE_EN
                    if (carry) begin
                        b_d = {WIDTH{1'b1}};
                        f_d = {WIDTH{1'b1}};
                    end else begin
                        b_d = sum[WIDTH-1:0];
                        f_d = sum[WIDTH-1:0];
                    end
`else
                    b_d = sum[WIDTH-1:0];
                    f_d = sum[WIDTH-1:0];
`endif
                end
                CtlRsvd: begin
                    valid_d = 1'b0;
                end
                default: begin
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            en_q    <= en;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign f     = f_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;
    assign count = count_q;

endmodule

// File: tb/tb_fls_datapath.sv
// Self-checking bench for fls_datapath against an arithmetic model of the sequence rules.
module tb_fls_datapath;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 8;
    localparam longint MOD     = longint'(1) << W;
    localparam longint CMAX    = (longint'(1) << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    control = 2'd0;
    logic [W-1:0]  d = '0;
    logic [W-1:0]  f;
    logic          valid;
    logic          ovf;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, kept as plain integers.
    longint m_a, m_b, m_f, m_cnt;
    bit     m_ovf;

    fls_datapath #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .control (control),
        .d       (d),
        .f       (f),
        .valid   (valid),
        .ovf     (ovf),
        .count   (count)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_a = 0; m_b = 0; m_f = 0; m_cnt = 0; m_ovf = 1'b0;
    endfunction

    // Returns 1 when the action produces a valid pulse.
    function automatic bit model_apply(int c, longint dv);
        longint s;
        case (c)
            0: begin m_a = dv; m_f = dv; m_b = 0; m_cnt = 1; m_ovf = 1'b0; return 1'b1; end
            1: begin m_b = dv; m_f = dv; m_cnt = 2; return 1'b1; end
            2: begin
                s = m_a + m_b;
                m_a = m_b;
                if (s >= MOD) begin
                    m_ovf = 1'b1;
`ifdef FLS_SATURATE_EN
                    s = MOD - 1;
`else
                    s = s % MOD;
`endif
                end
                m_b = s;
                m_f = s;
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                return 1'b1;
            end
            default: return 1'b0;
        endcase
    endfunction

    // One press: en high for one cycle, low for one cycle; checks the update and the pulse width.
    task automatic press(input int c, input logic [W-1:0] dv, input string tag);
        bit exp_v;
        exp_v = model_apply(c, longint'(dv));
        @(negedge clk);
        en = 1'b1; control = 2'(c); d = dv;
        @(posedge clk); #1;
        n_checks++;
        if (f !== W'(m_f) || count !== CW'(m_cnt) || ovf !== m_ovf || valid !== exp_v) begin
            n_fail++;
            $display("FAIL %s: f=%h count=%0d ovf=%b valid=%b, required f=%h count=%0d ovf=%b valid=%b",
                     tag, f, count, ovf, valid, W'(m_f), CW'(m_cnt), m_ovf, exp_v);
        end
        @(negedge clk);
        en = 1'b0; d = W'($urandom);
        @(posedge clk); #1;
        n_checks++;
        if (valid !== 1'b0 || f !== W'(m_f)) begin
            n_fail++;
            $display("FAIL %s_after: valid=%b f=%h, required valid=0 f=%h", tag, valid, f, W'(m_f));
        end
    endtask

    task automatic test_reset();
        // Reset asserted from time 0: outputs cleared before any clock edge.
        #1;
        n_checks++;
        if (f !== '0 || count !== '0 || ovf !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: f=%h count=%0d ovf=%b valid=%b, required all 0",
                     f, count, ovf, valid);
        end
        @(negedge clk); rst = 1'b0;
        model_reset();
        press(0, 16'h1234, "pre_async_load");
        press(1, 16'h0042, "pre_async_loadb");
        // Assert reset mid-cycle and check before the next edge.
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (f !== '0 || count !== '0 || ovf !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: f=%h count=%0d ovf=%b valid=%b, required all 0",
                     f, count, ovf, valid);
        end
        @(negedge clk); rst = 1'b0;
        model_reset();
    endtask

    task automatic test_sequence();
        press(0, 16'd1, "seq_load_a");
        press(1, 16'd1, "seq_load_b");
        for (int i = 0; i < 4; i++) press(2, W'($urandom), "seq_step");
        n_checks++;
        if (f !== 16'd8 || count !== 8'd6 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_final: f=%0d count=%0d ovf=%b, required f=8 count=6 ovf=0",
                     f, count, ovf);
        end
    endtask

    task automatic test_hold();
        int pulses;
        press(0, 16'd2, "hold_load_a");
        press(1, 16'd3, "hold_load_b");
        void'(model_apply(2, 0));
        pulses = 0;
        @(negedge clk);
        en = 1'b1; control = 2'd2;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) pulses++;
        end
        @(negedge clk); en = 1'b0;
        @(posedge clk); #1;
        if (valid === 1'b1) pulses++;
        n_checks++;
        if (pulses != 1 || f !== 16'd5 || count !== 8'd3) begin
            n_fail++;
            $display("FAIL hold: pulses=%0d f=%0d count=%0d, required pulses=1 f=5 count=3",
                     pulses, f, count);
        end
    endtask

    task automatic test_overflow();
        press(0, 16'h8000, "ovf_load_a");
        press(1, 16'h8000, "ovf_load_b");
        press(2, 16'h0000, "ovf_step");
        n_checks++;
`ifdef FLS_SATURATE_EN
        if (f !== 16'hFFFF || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sat: f=%h ovf=%b, required f=ffff ovf=1", f, ovf);
        end
`else
        if (f !== 16'h0000 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_wrap: f=%h ovf=%b, required f=0000 ovf=1", f, ovf);
        end
`endif
        press(2, 16'h0000, "ovf_sticky");
        press(0, 16'h0005, "ovf_clear");
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_cleared: ovf=%b, required 0", ovf);
        end
    endtask

    task automatic test_reserved();
        press(1, 16'h0010, "rsv_setup");
        press(3, W'($urandom), "rsv_press");
        // Step afterwards exposes any hidden change to a or b.
        press(2, 16'h0000, "rsv_step");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            press(int'($urandom_range(0, 3)), W'($urandom), "rand");
        end
        // Long run of steps drives the counter into saturation.
        press(0, W'($urandom_range(0, 3)), "sat_load");
        for (int i = 0; i < 260; i++) press(2, '0, "sat_step");
        n_checks++;
        if (count !== 8'hFF) begin
            n_fail++;
            $display("FAIL count_sat: count=%0d, required 255", count);
        end
    endtask

    task automatic test_reset_mid();
        press(0, 16'd4, "mid_load_a");
        press(1, 16'd9, "mid_load_b");
        for (int i = 0; i < 3; i++) press(2, '0, "mid_step");
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        press(0, 16'd7, "mid_reload");
        n_checks++;
        if (f !== 16'd7 || count !== 8'd1 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reload_val: f=%0d count=%0d ovf=%b, required f=7 count=1 ovf=0",
                     f, count, ovf);
        end
        press(2, '0, "mid_fresh_step");
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_hold();
        test_overflow();
        test_reserved();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
